// File: rtl/left_normalizer_pipe_pkg.sv
// Shared sizing constants for the posit normalizer data path (left and right shifters).
// The data path width is derived from the posit width N.
package left_normalizer_pipe_pkg;

  localparam int N_DEF = 8;

  function automatic int data_width_of(input int n);
    return 10 * n - 24;
  endfunction

  localparam int DATA_WIDTH_DEF = data_width_of(N_DEF);
  localparam int SHIFT_BITS_DEF = 6;
  localparam int MAX_SHIFT_DEF  = 48;

endpackage

// File: rtl/left_normalizer_pipe_leading_zero_counter.sv
// Combinational leading-zero counter: zeros above the most significant one of x_i.
// An all-zero input reports count 0 with zero_o set.
module leading_zero_counter
  import left_normalizer_pipe_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int SHIFT_BITS = SHIFT_BITS_DEF
) (
  input  logic [DATA_WIDTH-1:0] x_i,
  output logic [SHIFT_BITS-1:0] count_o,
  output logic                  zero_o
);

  // Scanning upward lets the highest set bit win the final assignment.
  always_comb begin
    count_o = '0;
    zero_o  = 1'b1;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (x_i[i]) begin
        count_o = SHIFT_BITS'(DATA_WIDTH - 1 - i);
        zero_o  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/left_normalizer_pipe.sv
// Two-stage left normalizer: S1 registers X with its leading-zero count, S2 registers
// the shifted result (shift clamped at MAX_SHIFT) with its zero/saturation flags.
module left_normalizer_pipe
  import left_normalizer_pipe_pkg::*;
#(
  parameter int N          = N_DEF,
  parameter int DATA_WIDTH = data_width_of(N),
  parameter int SHIFT_BITS = SHIFT_BITS_DEF,
  parameter int MAX_SHIFT  = MAX_SHIFT_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] X,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] R,
  output logic [SHIFT_BITS-1:0] count,
  output logic                  zero,
  output logic                  sat
);

  localparam logic [SHIFT_BITS-1:0] MAX_SHIFT_C = SHIFT_BITS'(MAX_SHIFT);

  // Handshake: a transfer happens on a rising edge when valid and ready are both high;
  // valid never depends on ready, and a stage moves when it is empty or its successor moves.
  logic s1_adv, s2_adv;

  logic                  s1_valid_q, s1_valid_d;
  logic [DATA_WIDTH-1:0] s1_x_q, s1_x_d;
  logic [SHIFT_BITS-1:0] s1_lzc_q, s1_lzc_d;
  logic                  s1_zero_q, s1_zero_d;

  logic                  s2_valid_q, s2_valid_d;
  logic [DATA_WIDTH-1:0] s2_r_q, s2_r_d;
  logic [SHIFT_BITS-1:0] s2_count_q, s2_count_d;
  logic                  s2_zero_q, s2_zero_d;
  logic                  s2_sat_q, s2_sat_d;

  logic [SHIFT_BITS-1:0] lzc_c;
  logic                  lzc_zero_c;
  logic [SHIFT_BITS-1:0] shamt_c;
  logic                  sat_c;
  logic [DATA_WIDTH-1:0] shifted_c;

  leading_zero_counter #(
    .DATA_WIDTH(DATA_WIDTH),
    .SHIFT_BITS(SHIFT_BITS)
  ) u_lzc (
    .x_i    (X),
    .count_o(lzc_c),
    .zero_o (lzc_zero_c)
  );

  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;

  // Clamp the shift, then run a log2 barrel: stage k shifts by 2**k, zero-filling the LSBs.
  always_comb begin
    sat_c     = !s1_zero_q && (s1_lzc_q > MAX_SHIFT_C);
    shamt_c   = s1_zero_q ? '0 : (sat_c ? MAX_SHIFT_C : s1_lzc_q);
    shifted_c = s1_x_q;
    for (int k = 0; k < SHIFT_BITS; k++) begin
      if (shamt_c[k]) begin
        shifted_c = shifted_c << (1 << k);
      end
    end
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_x_d     = s1_x_q;
    s1_lzc_d   = s1_lzc_q;
    s1_zero_d  = s1_zero_q;
    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_x_d    = X;
        s1_lzc_d  = lzc_c;
        s1_zero_d = lzc_zero_c;
      end
    end
  end

  // S2 result fields only change when a new item is loaded, so they hold while stalled.
  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_r_d     = s2_r_q;
    s2_count_d = s2_count_q;
    s2_zero_d  = s2_zero_q;
    s2_sat_d   = s2_sat_q;
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_r_d     = shifted_c;
        s2_count_d = shamt_c;
        s2_zero_d  = s1_zero_q;
        s2_sat_d   = sat_c;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_x_q     <= '0;
      s1_lzc_q   <= '0;
      s1_zero_q  <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_r_q     <= '0;
      s2_count_q <= '0;
      s2_zero_q  <= 1'b0;
      s2_sat_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_x_q     <= s1_x_d;
      s1_lzc_q   <= s1_lzc_d;
      s1_zero_q  <= s1_zero_d;
      s2_valid_q <= s2_valid_d;
      s2_r_q     <= s2_r_d;
      s2_count_q <= s2_count_d;
      s2_zero_q  <= s2_zero_d;
      s2_sat_q   <= s2_sat_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign R         = s2_r_q;
  assign count     = s2_count_q;
  assign zero      = s2_zero_q;
  assign sat       = s2_sat_q;

endmodule

// File: tb/tb_left_normalizer_pipe.sv
// Directed bench for left_normalizer_pipe: latency, clamping, stall hold, streaming and reset flush.
module tb_left_normalizer_pipe;

  localparam int DW = 56;
  localparam int SB = 6;
  localparam int W  = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] X;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] R;
  logic [SB-1:0] count;
  logic          zero;
  logic          sat;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_e;
  int n_cmp = 0;
  int n_err = 0;
  int cyc;

  logic [DW-1:0] vx[8];
  logic [DW-1:0] vr[8];
  logic [SB-1:0] vc[8];
  logic          vz[8];
  logic          vs[8];

  left_normalizer_pipe dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .X        (X),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .R        (R),
    .count    (count),
    .zero     (zero),
    .sat      (sat)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp_v);
    end
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", 64'(out_valid), 64'd0);
      end else begin
        exp_e = exp_q.pop_front();
        check("R", 64'(R), 64'(exp_e[63:8]));
        check("count", 64'(count), 64'(exp_e[7:2]));
        check("zero", 64'(zero), 64'(exp_e[1]));
        check("sat", 64'(sat), 64'(exp_e[0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_exp(input int i);
    exp_q.push_back({vr[i], vc[i], vz[i], vs[i]});
  endtask

  task automatic send_one(input int i);
    check("in_ready_idle", 64'(in_ready), 64'd1);
    push_exp(i);
    in_valid = 1'b1;
    X        = vx[i];
    cyc      = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) in_valid = 1'b0;
    end while (!out_valid && cyc < 10);
    check("latency", 64'(cyc), 64'd2);
    @(posedge clk); #1;
    check("drained", 64'(out_valid), 64'd0);
  endtask

  task automatic drain();
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    vx[0] = 56'h80_0000_0000_0000; vr[0] = 56'h80_0000_0000_0000; vc[0] = 6'd0;  vz[0] = 0; vs[0] = 0;
    vx[1] = 56'h00_1000_0000_0000; vr[1] = 56'h80_0000_0000_0000; vc[1] = 6'd11; vz[1] = 0; vs[1] = 0;
    vx[2] = 56'h00_0000_0000_0001; vr[2] = 56'h01_0000_0000_0000; vc[2] = 6'd48; vz[2] = 0; vs[2] = 1;
    vx[3] = 56'h00_0000_0000_0000; vr[3] = 56'h00_0000_0000_0000; vc[3] = 6'd0;  vz[3] = 1; vs[3] = 0;
    vx[4] = 56'h00_0000_0000_00FF; vr[4] = 56'hFF_0000_0000_0000; vc[4] = 6'd48; vz[4] = 0; vs[4] = 0;
    vx[5] = 56'h00_0000_0000_0100; vr[5] = 56'h80_0000_0000_0000; vc[5] = 6'd47; vz[5] = 0; vs[5] = 0;
    vx[6] = 56'h00_0000_0000_0002; vr[6] = 56'h02_0000_0000_0000; vc[6] = 6'd48; vz[6] = 0; vs[6] = 1;
    vx[7] = 56'h40_0000_0000_0001; vr[7] = 56'h80_0000_0000_0002; vc[7] = 6'd1;  vz[7] = 0; vs[7] = 0;

    rst       = 1'b1;
    in_valid  = 1'b0;
    X         = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_R", 64'(R), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_zero", 64'(zero), 64'd0);
    check("rst_sat", 64'(sat), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("in_ready_after_rst", 64'(in_ready), 64'd1);

    // Single items: latency and every result class.
    for (int i = 0; i < 8; i++) send_one(i);

    // Back-to-back stream: one result per cycle, no bubbles.
    for (int i = 4; i < 8; i++) begin
      check("in_ready_stream", 64'(in_ready), 64'd1);
      in_valid = 1'b1;
      X        = vx[i];
      push_exp(i);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk); #1;
    check("stream_no_bubble", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;

    // Stall: out_ready low for 4 edges with three distinct inputs offered.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    X         = vx[1];
    push_exp(1);
    @(posedge clk); #1;
    X = vx[2];
    push_exp(2);
    @(posedge clk); #1;
    X = vx[5];
    for (int k = 0; k < 2; k++) begin
      check("stall_in_ready", 64'(in_ready), 64'd0);
      check("stall_out_valid", 64'(out_valid), 64'd1);
      check("stall_R", 64'(R), 64'(vr[1]));
      check("stall_count", 64'(count), 64'(vc[1]));
      @(posedge clk); #1;
    end
    check("stall_R_hold", 64'(R), 64'(vr[1]));
    out_ready = 1'b1;
    #1;
    check("in_ready_release", 64'(in_ready), 64'd1);
    push_exp(5);
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain();
    @(posedge clk); #1;

    // Reset with both stages full flushes everything.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    X         = vx[0];
    @(posedge clk); #1;
    X = vx[3];
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("full_out_valid", 64'(out_valid), 64'd1);
    check("full_in_ready", 64'(in_ready), 64'd0);
    rst = 1'b1;
    #1;
    check("async_rst_out_valid", 64'(out_valid), 64'd0);
    check("async_rst_R", 64'(R), 64'd0);
    check("async_rst_in_ready", 64'(in_ready), 64'd1);
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("no_stale_out", 64'(out_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/left_normalizer_pipe.md
LEFT_NORMALIZER_PIPE -- requirements
Module: left_normalizer_pipe

Interface
REQ-001 Parameter N, default 8: posit width; all widths derive from it.
REQ-002 Parameter DATA_WIDTH, default 56 (10*N-24): data path width.
REQ-003 Parameter SHIFT_BITS, default 6: width of the shift-count output.
REQ-004 Parameter MAX_SHIFT, default 48: largest left shift applied.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 in_valid  input  1  X is offered this cycle.
REQ-008 in_ready  output  1  block accepts X this cycle.
REQ-009 X  input  DATA_WIDTH  unsigned magnitude to normalize.
REQ-010 out_valid  output  1  result fields are valid.
REQ-011 out_ready  input  1  downstream accepts result.
REQ-012 R  output  DATA_WIDTH  X shifted left, zero-filled from the LSB.
REQ-013 count  output  SHIFT_BITS  shift amount applied to R.
REQ-014 zero  output  1  X was all zeros.
REQ-015 sat  output  1  leading-zero count exceeded MAX_SHIFT.

Function
REQ-016 Transfer in: in_valid & in_ready on a rising edge; transfer out: out_valid & out_ready.
REQ-017 Two register stages: S1 captures X and its leading-zero count; S2 captures shifted R and flags.
REQ-018 Latency is exactly 2 cycles from input transfer to out_valid when out_ready stays high; throughput is one result per cycle.
REQ-019 Stage k advances when it is empty or stage k+1 advances; in_ready = !S1_valid | S2 advances; combinational path from out_ready to in_ready.
REQ-020 With out_ready low, S2 holds R, count, zero, sat and out_valid stable until transfer.
REQ-021 Results leave in acceptance order; no result dropped or duplicated.
REQ-022 lzc = number of zeros above the most significant one of X.
REQ-023 lzc <= MAX_SHIFT: count = lzc, R = X << lzc (R MSB = 1), sat = 0.
REQ-024 lzc > MAX_SHIFT and X != 0: count = MAX_SHIFT, R = X << MAX_SHIFT, sat = 1.
REQ-025 X == 0: R = 0, count = 0, zero = 1, sat = 0.
REQ-026 Fill bits entering from the LSB are always 0.
REQ-027 Shift implemented as a log2 staged barrel (1,2,4,...), stages beyond SHIFT_BITS omitted.
REQ-028 Simultaneous output transfer and input transfer in the same cycle with both stages full: both stages advance, no bubble.

Reset
REQ-029 While rst is high: S1_valid = 0, S2_valid = 0, out_valid = 0, R = 0, count = 0, zero = 0, sat = 0.
REQ-030 in_ready reads 1 during reset deassertion's first cycle onward (pipeline empty).
REQ-031 rst asserted mid-operation discards all in-flight data; no result emerges afterward for it.

Structure
REQ-032 Shared package holds DATA_WIDTH derivation from N, SHIFT_BITS, and MAX_SHIFT constants, shared with the right shifter.
REQ-033 One sub-module: leading_zero_counter (combinational, DATA_WIDTH in, SHIFT_BITS-wide count plus all-zero flag out).

Verification
REQ-034 X=56'h80_0000_0000_0000, out_ready=1 -> 2 cycles later R=X, count=0, zero=0, sat=0.
REQ-035 X=56'h00_1000_0000_0000 -> R=56'h80_0000_0000_0000, count=11, sat=0.
REQ-036 X=56'h00_0000_0000_0001 -> R=56'h01_0000_0000_0000, count=48, sat=1.
REQ-037 X=0 -> R=0, count=0, zero=1, sat=0.
REQ-038 out_ready low 4 cycles, in_valid high with 3 distinct X -> 2 accepted, in_ready low, outputs stable; on release results emerge in order, third accepted.
REQ-039 rst pulsed with both stages full -> out_valid=0 within the same cycle, no stale result after release.
